sram_like_arbiter: RTL

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_order_fifo.sv | 56 +++++
 rtl/sram_like_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like arbiter: transfer size encodings,
// channel limit and a constant log2 helper.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int MAX_NCH = 8;

    // Never returns less than 1 so that single-entry ranges still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_arb_order_fifo.sv
// Acceptance-order FIFO of channel IDs; pointers wrap modulo DEPTH (power of 2).
// Push and pop in one cycle are both honoured, even when full.
module sram_arb_order_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [ID_W-1:0]          i_din,
    input  logic                     i_pop,
    output logic [ID_W-1:0]          o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [clog2(DEPTH):0]    o_count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter of NCH SRAM-like masters onto one slave port, with
// in-order response routing. Define SRAM_ARB_RDATA_REG_EN to register m_data_ok/m_rdata.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            m_req,
    input  logic [NCH-1:0]            m_wr,
    input  logic [2*NCH-1:0]          m_size,
    input  logic [NCH*DATA_W/8-1:0]   m_wstrb,
    input  logic [NCH*ADDR_W-1:0]     m_addr,
    input  logic [NCH*DATA_W-1:0]     m_wdata,
    output logic [NCH-1:0]            m_addr_ok,
    output logic [NCH-1:0]            m_data_ok,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      s_req,
    output logic                      s_wr,
    output logic [1:0]                s_size,
    output logic [DATA_W/8-1:0]       s_wstrb,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic                      s_addr_ok,
    input  logic                      s_data_ok,
    input  logic [DATA_W-1:0]         s_rdata,
    output logic                      err_unexp
);

    localparam int IDW   = clog2(NCH);
    localparam int CNT_W = clog2(MAX_OUT) + 1;
    localparam int SW    = DATA_W / 8;

    logic [IDW-1:0]   r_rr_ptr;
    logic             r_lock;
    logic [IDW-1:0]   r_lock_ch;
    logic             r_err;

    logic [2*NCH-1:0] w_req_dbl;
    logic [IDW-1:0]   w_ofs;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_rr_gnt;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_next_ptr;
    logic             w_hs;
    logic             w_pop;
    logic [IDW-1:0]   w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [NCH-1:0]   w_resp_oh;

    // Rotate requests so the search always starts at rr_ptr.
    assign w_req_dbl = {m_req, m_req} >> r_rr_ptr;

    always_comb begin
        w_ofs = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_req_dbl[i]) w_ofs = IDW'(i);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
        if (w_sum >= (IDW+1)'(NCH)) w_sum = w_sum - (IDW+1)'(NCH);
        w_rr_gnt = w_sum[IDW-1:0];
    end

    assign w_grant    = r_lock ? r_lock_ch : w_rr_gnt;
    assign w_next_ptr = (w_grant == IDW'(NCH - 1)) ? '0 : w_grant + 1'b1;
    assign s_req      = (|m_req) && !w_full && (w_count < CNT_W'(MAX_OUT));
    assign w_hs       = s_req && s_addr_ok;
    assign w_pop      = s_data_ok && !w_empty;
    assign err_unexp  = r_err;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        w_resp_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == IDW'(i)) begin
                s_wr         = m_wr[i];
                s_size       = m_size[2*i +: 2];
                s_wstrb      = m_wstrb[SW*i +: SW];
                s_addr       = m_addr[ADDR_W*i +: ADDR_W];
                s_wdata      = m_wdata[DATA_W*i +: DATA_W];
                m_addr_ok[i] = w_hs;
            end
            if (w_head == IDW'(i)) w_resp_oh[i] = w_pop;
        end
    end

    // A pending request keeps its channel until the slave accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_hs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_next_ptr;
            end else if (s_req) begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_grant;
            end
            if (s_data_ok && w_empty) r_err <= 1'b1;
        end
    end

    sram_arb_order_fifo #(
        .DEPTH (MAX_OUT),
        .ID_W  (IDW)
    ) u_order_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_hs),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef SRAM_ARB_RDATA_REG_EN
    logic [NCH-1:0]    r_data_ok;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_ok <= '0;
            r_rdata   <= '0;
        end else begin
            r_data_ok <= w_resp_oh;
            if (w_pop) r_rdata <= s_rdata;
        end
    end

    assign m_data_ok = r_data_ok;
    assign m_rdata   = r_rdata;
`else
    assign m_data_ok = w_resp_oh;
    assign m_rdata   = s_rdata;
`endif

endmodule
